adc_multi_capture: RTL

//  Parametrised serial-ADC capture engine for stonyman pixel readout. Drives shared SCLK/CS_N
//  to NUM_ADC TI ADCxx1S101-class converters in lockstep, deserialises all channels at once,

---
 rtl/adc_multi_capture_pkg.sv | 22 ++
 rtl/adc_multi_capture_sclk_gen.sv | 45 ++++
 rtl/adc_multi_capture.sv | 123 ++++++++++++
 3 files changed

// File: rtl/adc_multi_capture_pkg.sv
// Shared state encoding and helpers for the multi-channel serial ADC capture engine.
package adc_multi_capture_pkg;

    localparam int STATE_BITS = 3;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE  = 3'd0,
        ST_TRACK = 3'd1,
        ST_ZEROS = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/adc_multi_capture_sclk_gen.sv
// SCLK generator: idles high, restarts low on load, toggles every SCLK_HALF clk cycles.
module adc_multi_capture_sclk_gen #(
    parameter int SCLK_HALF = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic load,
    input  logic idle,
    output logic sclk,
    output logic fall_tick,
    output logic period_tick
);

    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    logic [HW-1:0] cnt;
    logic          half_end;

    assign half_end    = (cnt == HW'(SCLK_HALF - 1));
    // Every SCLK period starts low, so each one ends on the 1->0 edge.
    assign fall_tick   = enable && sclk && half_end;
    assign period_tick = fall_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk <= 1'b1;
            cnt  <= '0;
        end else if (load) begin
            sclk <= 1'b0;
            cnt  <= '0;
        end else if (idle) begin
            sclk <= 1'b1;
            cnt  <= '0;
        end else if (enable) begin
            if (half_end) begin
                cnt  <= '0;
                sclk <= ~sclk;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_multi_capture.sv
// Lockstep capture of NUM_ADC serial converters, then an in-order drain into the pixel FIFO.
module adc_multi_capture
    import adc_multi_capture_pkg::*;
#(
    parameter int NUM_ADC      = 1,
    parameter int ADC_BITS     = 12,
    parameter int LEAD_ZEROS   = 3,
    parameter int TRACK_CYCLES = 14,
    parameter int SCLK_HALF    = 1,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  adc_capture_start,
    input  logic                  align_msb,
    input  logic                  fifo_full,
    input  logic [NUM_ADC-1:0]    sdata,
    output logic                  adc_capture_done,
    output logic                  capture_overrun,
    output logic                  fifo_write_enable,
    output logic [OUT_WIDTH-1:0]  fifo_write_data,
    output logic                  sclk,
    output logic                  cs_n,
    output logic [STATE_BITS-1:0] fsm_state
);

    localparam int MAX_COUNT = max3(TRACK_CYCLES, LEAD_ZEROS, ADC_BITS);
    localparam int TW        = $clog2(MAX_COUNT + 1);
    localparam int CW        = $clog2(NUM_ADC) + 1;

    state_t               state, state_next;
    logic [TW-1:0]        timer;
    logic [CW-1:0]        ch;
    logic                 pending, req, consume, last_write;
    logic                 active, active_next, track_exit;
    logic                 fall_tick, period_tick;
    logic [ADC_BITS-1:0]  sample [NUM_ADC];
    logic [ADC_BITS-1:0]  cur_sample;
    logic [OUT_WIDTH-1:0] aligned;

    assign req         = adc_capture_start | pending;
    assign active      = (state == ST_ZEROS) || (state == ST_READ);
    assign active_next = (state_next == ST_ZEROS) || (state_next == ST_READ);
    assign track_exit  = (state == ST_TRACK) && active_next;
    assign last_write  = (state == ST_DRAIN) && !fifo_full && (ch == CW'(NUM_ADC - 1));
    assign consume     = req && ((state == ST_IDLE) || last_write);
    assign fsm_state   = state;

    adc_multi_capture_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (active),
        .load        (track_exit),
        .idle        (!active_next),
        .sclk        (sclk),
        .fall_tick   (fall_tick),
        .period_tick (period_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req) state_next = ST_TRACK;
            ST_TRACK: if (timer == TW'(TRACK_CYCLES - 1))
                          state_next = (LEAD_ZEROS == 0) ? ST_READ : ST_ZEROS;
            ST_ZEROS: if (period_tick && timer == TW'(LEAD_ZEROS - 1)) state_next = ST_READ;
            ST_READ:  if (fall_tick && timer == TW'(ADC_BITS - 1)) state_next = ST_DRAIN;
            ST_DRAIN: if (last_write) state_next = req ? ST_TRACK : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_sample = '0;
        for (int k = 0; k < NUM_ADC; k++) begin
            if (ch == CW'(k)) cur_sample = sample[k];
        end
        aligned = align_msb ? cur_sample[ADC_BITS-1 -: OUT_WIDTH] : cur_sample[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer             <= '0;
            ch                <= '0;
            pending           <= 1'b0;
            cs_n              <= 1'b1;
            adc_capture_done  <= 1'b0;
            capture_overrun   <= 1'b0;
            fifo_write_enable <= 1'b0;
            fifo_write_data   <= '0;
            for (int k = 0; k < NUM_ADC; k++) sample[k] <= '0;
        end else begin
            adc_capture_done <= track_exit;
            cs_n             <= !active_next;
            // Any request seen while one is already queued is folded into it.
            capture_overrun  <= adc_capture_start && pending;
            if (consume)                                      pending <= 1'b0;
            else if (adc_capture_start && state != ST_IDLE)   pending <= 1'b1;

            if (state_next != state)
                timer <= '0;
            else if ((state == ST_TRACK) || (active && period_tick))
                timer <= timer + 1'b1;

            if (state_next != ST_DRAIN)                 ch <= '0;
            else if (state == ST_DRAIN && !fifo_full)   ch <= ch + 1'b1;

            fifo_write_enable <= (state == ST_DRAIN) && !fifo_full;
            if (state == ST_DRAIN && !fifo_full) fifo_write_data <= aligned;

            if (state == ST_READ && fall_tick) begin
                for (int k = 0; k < NUM_ADC; k++)
                    sample[k] <= (sample[k] << 1) | ADC_BITS'(sdata[k]);
            end
        end
    end

endmodule
